// File: rtl/inst_prefetch_queue_pkg.sv
// Shared constants and helpers for the instruction prefetch queue.
package inst_prefetch_queue_pkg;

    localparam int unsigned MAX_INST_LEN = 6;
    localparam int unsigned ROM_LATENCY  = 1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/inst_prefetch_queue_window_mux.sv
// Rotates the circular byte store from the read pointer into the decode window,
// zeroing bytes at or above the valid count.
module inst_prefetch_queue_window_mux
    import inst_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned WIN_BYTES = MAX_INST_LEN,
    localparam int unsigned PtrW     = clog2(DEPTH),
    localparam int unsigned WinW     = clog2(WIN_BYTES) + 1
) (
    input  logic [7:0]             mem_i [DEPTH],
    input  logic [PtrW-1:0]        rd_ptr_i,
    input  logic [WinW-1:0]        win_count_i,
    output logic [8*WIN_BYTES-1:0] win_data_o
);

    always_comb begin
        win_data_o = '0;
        for (int unsigned i = 0; i < WIN_BYTES; i++) begin
            if (32'(win_count_i) > i) begin
                win_data_o[8*i +: 8] = mem_i[rd_ptr_i + PtrW'(i)];
            end
        end
    end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: fetches code bytes from a one-cycle ROM into a circular
// byte queue and presents the head window to the decoder.
module inst_prefetch_queue
    import inst_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned FETCH_BYTES = 1,
    parameter int unsigned WIN_BYTES   = MAX_INST_LEN,
    parameter int unsigned ADDR_W      = 20,
    localparam int unsigned PtrW       = clog2(DEPTH),
    localparam int unsigned CntW       = clog2(DEPTH) + 1,
    localparam int unsigned WinW       = clog2(WIN_BYTES) + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     rom_en_o,
    output logic [ADDR_W-1:0]        rom_addr_o,
    input  logic [8*FETCH_BYTES-1:0] rom_data_i,
    input  logic                     flush_i,
    input  logic [ADDR_W-1:0]        flush_addr_i,
    output logic [8*WIN_BYTES-1:0]   win_data_o,
    output logic [WinW-1:0]          win_count_o,
    output logic [ADDR_W-1:0]        head_addr_o,
    input  logic [WinW-1:0]          consume_len_i,
    output logic                     consume_err_o,
    output logic                     full_o
);

    localparam int unsigned OffW  = (FETCH_BYTES > 1) ? clog2(FETCH_BYTES) : 1;
    localparam int unsigned OffCW = OffW + 1;

    logic [7:0]        mem_q [DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d, head_addr_q, head_addr_d;
    logic              inflight_q;
    logic              consume_err_q, consume_err_d;

    logic [OffCW-1:0]  fetch_off;
    logic [CntW-1:0]   kept;
    logic [WinW-1:0]   win_count;
    logic              consume_ok;

    assign win_count = (count_q >= CntW'(WIN_BYTES)) ? WinW'(WIN_BYTES) : WinW'(count_q);
    assign consume_ok = (consume_len_i <= win_count);

    // Only the first fetch after an unaligned flush has a non-zero offset.
    assign fetch_off = OffCW'(32'(fetch_addr_q[OffW-1:0]) % FETCH_BYTES);
    assign kept      = CntW'(FETCH_BYTES) - CntW'(fetch_off);

    assign rom_en_o   = !rst_i && !flush_i && !inflight_q &&
                        ((CntW'(DEPTH) - count_q) >= CntW'(FETCH_BYTES));
    assign rom_addr_o = fetch_addr_q & ~ADDR_W'(FETCH_BYTES - 1);

    always_comb begin
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        fetch_addr_d  = fetch_addr_q;
        head_addr_d   = head_addr_q;
        consume_err_d = 1'b0;
        if (flush_i) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            fetch_addr_d = flush_addr_i;
            head_addr_d  = flush_addr_i;
        end else begin
            if (inflight_q) begin
                wr_ptr_d     = wr_ptr_q + PtrW'(kept);
                fetch_addr_d = fetch_addr_q + ADDR_W'(kept);
            end
            if (consume_ok) begin
                rd_ptr_d    = rd_ptr_q + PtrW'(consume_len_i);
                head_addr_d = head_addr_q + ADDR_W'(consume_len_i);
            end else begin
                consume_err_d = 1'b1;
            end
            count_d = count_q + (inflight_q ? kept : '0)
                    - (consume_ok ? CntW'(consume_len_i) : '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            fetch_addr_q  <= '0;
            head_addr_q   <= '0;
            inflight_q    <= 1'b0;
            consume_err_q <= 1'b0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            fetch_addr_q  <= fetch_addr_d;
            head_addr_q   <= head_addr_d;
            inflight_q    <= rom_en_o;
            consume_err_q <= consume_err_d;
        end
    end

    // A response returning during reset or flush is dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && inflight_q) begin
            for (int unsigned j = 0; j < FETCH_BYTES; j++) begin
                if (j >= 32'(fetch_off)) begin
                    mem_q[wr_ptr_q + PtrW'(j - 32'(fetch_off))] <= rom_data_i[8*j +: 8];
                end
            end
        end
    end

    inst_prefetch_queue_window_mux #(
        .DEPTH    (DEPTH),
        .WIN_BYTES(WIN_BYTES)
    ) u_window_mux (
        .mem_i      (mem_q),
        .rd_ptr_i   (rd_ptr_q),
        .win_count_i(win_count),
        .win_data_o (win_data_o)
    );

    assign win_count_o   = win_count;
    assign head_addr_o   = head_addr_q;
    assign consume_err_o = consume_err_q;
    assign full_o        = (count_q == CntW'(DEPTH));

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: phase table checked against a byte-queue model,
// plus a hand sequence for the two-byte-fetch unaligned restart.
module tb_inst_prefetch_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 1: DEPTH=8, FETCH_BYTES=1
    logic        rst1, flush1, rom_en1, err1, full1;
    logic [19:0] fa1, rom_addr1, head1;
    logic [7:0]  rom_data1;
    logic [47:0] wd1;
    logic [3:0]  wc1, cl1;

    // DUT 2: DEPTH=8, FETCH_BYTES=2
    logic        rst2, flush2, rom_en2, err2, full2;
    logic [19:0] fa2, rom_addr2, head2;
    logic [15:0] rom_data2;
    logic [47:0] wd2;
    logic [3:0]  wc2, cl2;

    inst_prefetch_queue #(
        .DEPTH(8), .FETCH_BYTES(1), .WIN_BYTES(6), .ADDR_W(20)
    ) dut1 (
        .clk_i(clk), .rst_i(rst1), .rom_en_o(rom_en1), .rom_addr_o(rom_addr1),
        .rom_data_i(rom_data1), .flush_i(flush1), .flush_addr_i(fa1), .win_data_o(wd1),
        .win_count_o(wc1), .head_addr_o(head1), .consume_len_i(cl1),
        .consume_err_o(err1), .full_o(full1)
    );

    inst_prefetch_queue #(
        .DEPTH(8), .FETCH_BYTES(2), .WIN_BYTES(6), .ADDR_W(20)
    ) dut2 (
        .clk_i(clk), .rst_i(rst2), .rom_en_o(rom_en2), .rom_addr_o(rom_addr2),
        .rom_data_i(rom_data2), .flush_i(flush2), .flush_addr_i(fa2), .win_data_o(wd2),
        .win_count_o(wc2), .head_addr_o(head2), .consume_len_i(cl2),
        .consume_err_o(err2), .full_o(full2)
    );

    // ROM: byte at address a is a[7:0]; 0xEE when not read.
    always @(posedge clk) begin
        rom_data1 <= rom_en1 ? rom_addr1[7:0] : 8'hEE;
        rom_data2 <= rom_en2 ? {rom_addr2[7:0] + 8'd1, rom_addr2[7:0]} : 16'hEEEE;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard model for DUT 1: queue of expected bytes plus fetch/head addresses.
    logic [7:0]  m_q[$];
    logic [19:0] m_fetch, m_head;
    bit          m_inflight, m_err;

    function automatic logic [47:0] m_win();
        logic [47:0] w;
        w = '0;
        for (int i = 0; i < 6 && i < m_q.size(); i++) w[8*i +: 8] = m_q[i];
        return w;
    endfunction

    // cl_in < 0: consume one byte whenever the window is non-empty.
    task automatic cycle1(input bit r, input bit fl, input logic [19:0] fa, input int cl_in);
        int cl, wc;
        bit exp_en, ok;
        wc = (m_q.size() > 6) ? 6 : m_q.size();
        cl = (cl_in < 0) ? ((wc > 0) ? 1 : 0) : cl_in;
        rst1 = r; flush1 = fl; fa1 = fa; cl1 = 4'(cl);
        #1;
        exp_en = !r && !fl && !m_inflight && (m_q.size() < 8);
        chk("rom_en", 64'(rom_en1), 64'(exp_en));
        if (exp_en) chk("rom_addr", 64'(rom_addr1), 64'(m_fetch));
        chk("win_count", 64'(wc1), 64'(wc));
        chk("win_data", 64'(wd1), 64'(m_win()));
        chk("head_addr", 64'(head1), 64'(m_head));
        chk("consume_err", 64'(err1), 64'(m_err));
        chk("full", 64'(full1), 64'(m_q.size() == 8));
        if (r) begin
            m_q.delete(); m_fetch = '0; m_head = '0; m_inflight = 0; m_err = 0;
        end else if (fl) begin
            m_q.delete(); m_fetch = fa; m_head = fa; m_inflight = 0; m_err = 0;
        end else begin
            ok = (cl <= wc);
            m_err = !ok;
            if (ok) begin
                for (int i = 0; i < cl; i++) begin
                    chk("sb_byte", 64'(wd1[8*i +: 8]), 64'(m_q[0]));
                    void'(m_q.pop_front());
                end
                m_head = m_head + 20'(cl);
            end
            if (m_inflight) begin
                m_q.push_back(m_fetch[7:0]);
                m_fetch = m_fetch + 20'd1;
            end
            m_inflight = exp_en;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        bit          rst;
        bit          fl;
        logic [19:0] fa;
        int          cl;
        int          n;
        int          e_wc;
        logic [19:0] e_head;
        bit          e_full;
        bit          e_err;
        logic [47:0] e_wd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input bit fl, input logic [19:0] fa, input int cl,
                       input int n, input int e_wc, input logic [19:0] e_head,
                       input bit e_full, input bit e_err, input logic [47:0] e_wd);
        vec_t v;
        v.rst = r; v.fl = fl; v.fa = fa; v.cl = cl; v.n = n; v.e_wc = e_wc;
        v.e_head = e_head; v.e_full = e_full; v.e_err = e_err; v.e_wd = e_wd;
        vecs.push_back(v);
    endtask

    initial begin
        rst1 = 1'b1; flush1 = 1'b0; fa1 = '0; cl1 = '0;
        rst2 = 1'b1; flush2 = 1'b0; fa2 = '0; cl2 = '0;

        //  rst   fl    fa        cl  n   wc head      full  err   window
        add(1'b0, 1'b0, 20'h0,     0, 16, 6, 20'h0,     1'b1, 1'b0, 48'h050403020100);
        add(1'b0, 1'b0, 20'h0,     0,  2, 6, 20'h0,     1'b1, 1'b0, 48'h050403020100);
        add(1'b0, 1'b0, 20'h0,     3,  1, 5, 20'h3,     1'b0, 1'b0, 48'h000706050403);
        add(1'b0, 1'b0, 20'h0,     0,  1, 5, 20'h3,     1'b0, 1'b0, 48'h000706050403);
        add(1'b0, 1'b1, 20'h12345, 6,  1, 0, 20'h12345, 1'b0, 1'b0, 48'h0);
        add(1'b0, 1'b0, 20'h0,     0,  1, 0, 20'h12345, 1'b0, 1'b0, 48'h0);
        add(1'b0, 1'b0, 20'h0,     0,  1, 1, 20'h12345, 1'b0, 1'b0, 48'h45);
        add(1'b0, 1'b0, 20'h0,     0,  2, 2, 20'h12345, 1'b0, 1'b0, 48'h4645);
        add(1'b0, 1'b0, 20'h0,     4,  1, 2, 20'h12345, 1'b0, 1'b1, 48'h4645);
        add(1'b0, 1'b0, 20'h0,     0,  1, 3, 20'h12345, 1'b0, 1'b0, 48'h474645);
        add(1'b0, 1'b1, 20'hFFFFE, 0,  1, 0, 20'hFFFFE, 1'b0, 1'b0, 48'h0);
        add(1'b0, 1'b0, 20'h0,    -1, 40, 1, 20'h00011, 1'b0, 1'b0, 48'h11);
        add(1'b0, 1'b0, 20'h0,     1,  1, 0, 20'h00012, 1'b0, 1'b0, 48'h0);
        add(1'b0, 1'b0, 20'h0,     0,  1, 1, 20'h00012, 1'b0, 1'b0, 48'h12);
        add(1'b0, 1'b0, 20'h0,     0,  1, 1, 20'h00012, 1'b0, 1'b0, 48'h12);
        add(1'b1, 1'b0, 20'h0,     0,  1, 0, 20'h0,     1'b0, 1'b0, 48'h0);
        add(1'b0, 1'b0, 20'h0,     0,  4, 2, 20'h0,     1'b0, 1'b0, 48'h0100);

        repeat (2) @(posedge clk);
        @(negedge clk);
        m_q.delete(); m_fetch = '0; m_head = '0; m_inflight = 0; m_err = 0;
        chk("reset_win_count", 64'(wc1), 64'd0);
        chk("reset_head", 64'(head1), 64'd0);
        chk("reset_full", 64'(full1), 64'd0);
        chk("reset_err", 64'(err1), 64'd0);

        foreach (vecs[k]) begin
            for (int c = 0; c < vecs[k].n; c++) begin
                cycle1(vecs[k].rst, vecs[k].fl, vecs[k].fa, vecs[k].cl);
            end
            chk($sformatf("v%0d_wc", k), 64'(wc1), 64'(vecs[k].e_wc));
            chk($sformatf("v%0d_head", k), 64'(head1), 64'(vecs[k].e_head));
            chk($sformatf("v%0d_full", k), 64'(full1), 64'(vecs[k].e_full));
            chk($sformatf("v%0d_err", k), 64'(err1), 64'(vecs[k].e_err));
            chk($sformatf("v%0d_win", k), 64'(wd1), 64'(vecs[k].e_wd));
        end
        rst1 = 1'b0; flush1 = 1'b0; cl1 = '0;

        // Two-byte fetch: unaligned flush keeps only the upper byte of the first word.
        rst2 = 1'b0; flush2 = 1'b1; fa2 = 20'h00101;
        #1 chk("f2_flush_rom_en", 64'(rom_en2), 64'd0);
        @(posedge clk); @(negedge clk);
        flush2 = 1'b0;
        #1;
        chk("f2_rom_en", 64'(rom_en2), 64'd1);
        chk("f2_rom_addr", 64'(rom_addr2), 64'h00100);
        chk("f2_wc_empty", 64'(wc2), 64'd0);
        chk("f2_head", 64'(head2), 64'h00101);
        @(posedge clk); @(negedge clk);
        #1 chk("f2_inflight_rom_en", 64'(rom_en2), 64'd0);
        @(posedge clk); @(negedge clk);
        #1;
        chk("f2_wc_first", 64'(wc2), 64'd1);
        chk("f2_win_first", 64'(wd2), 64'h01);
        chk("f2_rom_addr_next", 64'(rom_addr2), 64'h00102);
        chk("f2_rom_en_next", 64'(rom_en2), 64'd1);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("f2_wc_second", 64'(wc2), 64'd3);
        chk("f2_win_second", 64'(wd2), 64'h030201);
        cl2 = 4'd2;
        @(posedge clk); @(negedge clk);
        cl2 = 4'd0;
        chk("f2_consume_wc", 64'(wc2), 64'd1);
        chk("f2_consume_head", 64'(head2), 64'h00103);
        chk("f2_consume_win", 64'(wd2), 64'h03);
        chk("f2_consume_err", 64'(err2), 64'd0);
        chk("f2_full", 64'(full2), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
